dup_tx_ctrl: RTL and testbench
==============================

// Module: dup_tx_ctrl
// PURPOSE
//  DUP11 transmitter sequencer. Moves bytes and flags written to TXDBUF through a holding register into an 8-bit shift register.
//  Serialises each byte LSB-first on modem bit ticks and accumulates CRC-16.
//  Appends the CRC on end-of-message, sends an abort pattern on request, and drives TXDONE/TXACT back to TXCSR.
// PARAMETERS
//  CRCPOLY   16'hA001  reflected CRC-16 polynomial (x^16+x^15+x^2+1)
//  ABRTBITS  8         consecutive mark bits sent for an abort
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, asynchronous, active-low
//  dupINIT    in   1   synchronous initialise; same effect as reset
//  txLOAD     in   1   one-cycle strobe: TXDBUF written (either byte)
//  txDAT      in   8   TXDBUF[7:0] value in the txLOAD cycle
//  txSOM      in   1   TXDBUF[8] value in the txLOAD cycle
//  txEOM      in   1   TXDBUF[9] value in the txLOAD cycle
//  txABRT     in   1   TXDBUF[10] value in the txLOAD cycle
//  txEN       in   1   TXCSR SEND; transmitter enable
//  txTICK     in   1   one-cycle bit-time strobe, already synchronised to clk
//  txDATA     out  1   serial line; 1 = mark
//  txDONE     out  1   holding register empty and txEN set
//  txACT      out  1   shifter busy (DATA, CRC or ABORT state)
//  dupTXCRC   out  1   crc[0], fed to TXDBUF bit 12
// BEHAVIOUR
//  Reset / dupINIT:
//   - state=IDLE; hold, shift and bit counters cleared; crc=0.
//   - txDATA=1, txDONE=0, txACT=0, dupTXCRC=0.
//  Holding register:
//   - txLOAD captures {ABRT,EOM,SOM,DAT} and sets holdFULL.
//   - txLOAD while holdFULL overwrites silently.
//   - txLOAD and a transfer in the same cycle: transfer takes the old contents; holdFULL stays 1 with the new contents.
//  txDONE: registered; = txEN & ~holdFULL, one cycle after the change.
//  All state changes and line updates occur only in txTICK cycles, except reset, dupINIT and txLOAD capture.
//  States:
//   IDLE:
//    - txDATA=1.
//    - On tick with txEN & holdFULL: ABRT -> ABORT; EOM -> CRC; else load shifter -> DATA.
//   DATA:
//    - Each tick drives shift[0] and shifts right; 8 ticks per byte.
//    - If the byte was loaded without SOM: crc updated per bit, fb=crc[0]^bit, crc=(crc>>1)^(fb?CRCPOLY:0).
//    - SOM byte: crc cleared at load and the byte is excluded from the CRC (sync character).
//    - After bit 7, with holdFULL & txEN: ABRT -> ABORT; EOM -> CRC; else reload -> DATA.
//    - Reload is back-to-back with no gap bit.
//    - After bit 7, with hold empty or ~txEN: -> IDLE (underrun; line idles at mark).
//   CRC:
//    - Entry clears holdFULL; the EOM byte's data field is not sent.
//    - Sends crc[15:0] LSB-first over 16 ticks and shifts crc right, filling with 0.
//    - Then crc=0 and -> IDLE, or direct reload per DATA rules.
//   ABORT:
//    - Entry clears holdFULL and crc.
//    - Sends ABRTBITS ones -> IDLE.
//  txABRT loaded during DATA or CRC takes effect at the next character boundary, not mid-byte.
//  txEN falling mid-character: the current character or CRC completes, then IDLE.
//  txACT=1 in DATA, CRC and ABORT states.
//  Bit counter width: 5 bits (covers 16 CRC bits); no wrap beyond the terminal count.
// STRUCTURE
//  Shared include dupdefs.vh:
//   - state encodings IDLE/DATA/CRC/ABORT
//   - CRC16POLY constant
//   - TXDBUF field macros already used for SOM/EOM/ABRT/DAT
//  Sub-module dup_crc16: one-bit serial update (enable, clear, bit in, crc out), reused later by the receiver.
//  Everything else stays flat in this module.
// TESTING
//  - Reset held, then released: txDATA=1, txDONE=0, txACT=0; txEN=1 gives txDONE=1 within 2 clocks.
//  - txEN=1, load 0x96 (no flags), tick x8: line carries 0,1,1,0,1,0,0,1, then IDLE; dupTXCRC tracks crc[0].
//  - Load SOM|0x96, then 0x31..0x39, then EOM: sync byte excluded; bytes contiguous; CRC bits = 16'hBB3D LSB-first; txDONE pulses between bytes.
//  - Load 0x55, then ABRT mid-byte: 0x55 completes, 8 mark bits follow, IDLE, crc=0, txDONE=1.
//  - Underrun: single byte, no reload -> txACT drops after bit 7, line idles at 1; a later load restarts cleanly.
//  - dupINIT asserted mid-CRC: next cycle is IDLE, txDATA=1, crc=0, holdFULL=0; txLOAD in the same cycle as dupINIT is discarded.

Source files
------------

// File: rtl/dup_tx_ctrl_pkg.sv
// DUP11 transmitter shared definitions.
// State encodings, TXDBUF fields, CRC-16 polynomial.
package dup_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC,
    ST_ABORT
  } tx_state_t;

  typedef struct packed {
    logic       abrt;
    logic       eom;
    logic       som;
    logic [7:0] dat;
  } txdbuf_t;

  localparam logic [15:0] CRC16POLY = 16'hA001;
  localparam int          ABRTBITS  = 8;

  function automatic tx_state_t next_char(input txdbuf_t h);
    tx_state_t s;
    s = ST_DATA;
    unique case (1'b1)
      h.abrt:  s = ST_ABORT;
      h.eom:   s = ST_CRC;
      default: s = ST_DATA;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dup_tx_ctrl_crc16.sv
// DUP11 serial CRC-16 accumulator, one bit per enable.
// Shared between transmitter and receiver.
module dup_crc16
  import dup_tx_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb  = r_crc[0] ^ i_bit;
  assign o_crc = r_crc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= (r_crc >> 1) ^ (w_fb ? CRC16POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/dup_tx_ctrl.sv
// DUP11 transmitter sequencer: holding register, shifter,
// CRC append and abort on modem bit ticks.
module dup_tx_ctrl
  import dup_tx_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dupINIT,
  input  logic       txLOAD,
  input  logic [7:0] txDAT,
  input  logic       txSOM,
  input  logic       txEOM,
  input  logic       txABRT,
  input  logic       txEN,
  input  logic       txTICK,
  output logic       txDATA,
  output logic       txDONE,
  output logic       txACT,
  output logic       dupTXCRC
);

  tx_state_t   r_state;
  tx_state_t   w_nstate;
  txdbuf_t     r_hold;
  logic        r_full;
  logic [7:0]  r_shift;
  logic [4:0]  r_bcnt;
  logic        r_crcon;
  logic        r_data;
  logic        r_done;
  logic [15:0] w_crc;
  logic        w_last;
  logic        w_take;
  logic        w_crcen;
  logic        w_crcclr;
  logic        w_crcbit;
  logic        w_unused_crc;

  always_comb begin
    w_last = 1'b1;
    unique case (r_state)
      ST_DATA:  w_last = (r_bcnt == 5'd7);
      ST_CRC:   w_last = (r_bcnt == 5'd15);
      ST_ABORT: w_last = (r_bcnt == 5'(ABRTBITS - 1));
      default:  w_last = 1'b1;
    endcase
    w_nstate = r_state;
    w_take   = 1'b0;
    if (txTICK && w_last) begin
      if (r_state != ST_ABORT && r_full && txEN) begin
        w_nstate = next_char(r_hold);
        w_take   = 1'b1;
      end else begin
        w_nstate = ST_IDLE;
      end
    end
  end

  // Sync bytes and abort reset the CRC; CRC send shifts by feeding back crc[0]
  assign w_crcclr = dupINIT
    | (w_take & (w_nstate == ST_ABORT))
    | (w_take & (w_nstate == ST_DATA) & r_hold.som)
    | (txTICK & w_last & (r_state == ST_CRC));
  assign w_crcen  = txTICK
    & (((r_state == ST_DATA) & r_crcon) | (r_state == ST_CRC));
  assign w_crcbit = (r_state == ST_CRC) ? w_crc[0] : r_shift[0];

  dup_crc16 u_crc (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (w_crcen),
    .i_clr   (w_crcclr),
    .i_bit   (w_crcbit),
    .o_crc   (w_crc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_full  <= 1'b0;
      r_shift <= '0;
      r_bcnt  <= '0;
      r_crcon <= 1'b0;
      r_data  <= 1'b1;
      r_done  <= 1'b0;
    end else if (dupINIT) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_full  <= 1'b0;
      r_shift <= '0;
      r_bcnt  <= '0;
      r_crcon <= 1'b0;
      r_data  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_done  <= txEN & ~r_full;
      if (txLOAD) begin
        r_hold <= txdbuf_t'({txABRT, txEOM, txSOM, txDAT});
        r_full <= 1'b1;
      end else if (w_take) begin
        r_full <= 1'b0;
      end
      if (txTICK) begin
        r_bcnt <= w_last ? 5'd0 : r_bcnt + 5'd1;
        unique case (r_state)
          ST_DATA: begin
            r_data  <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
          ST_CRC:  r_data <= w_crc[0];
          default: r_data <= 1'b1;
        endcase
        if (w_take && w_nstate == ST_DATA) begin
          r_shift <= r_hold.dat;
          r_crcon <= ~r_hold.som;
        end
      end
    end
  end

  assign w_unused_crc = ^w_crc[15:1];
  assign txDATA   = r_data;
  assign txDONE   = r_done;
  assign txACT    = (r_state != ST_IDLE);
  assign dupTXCRC = w_crc[0];

endmodule

// File: tb/tb_dup_tx_ctrl.sv
// Self-checking bench for dup_tx_ctrl against a
// character-level stream model of the transmitter.
module tb_dup_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dupINIT = 1'b0;
  logic       txLOAD = 1'b0;
  logic [7:0] txDAT = 8'h00;
  logic       txSOM = 1'b0;
  logic       txEOM = 1'b0;
  logic       txABRT = 1'b0;
  logic       txEN = 1'b0;
  logic       txTICK = 1'b0;
  logic       txDATA;
  logic       txDONE;
  logic       txACT;
  logic       dupTXCRC;

  int n_pass = 0;
  int n_tot  = 0;
  bit [15:0] m_crc = 16'h0000;

  typedef struct {
    bit       som;
    bit       eom;
    bit       abrt;
    bit [7:0] dat;
  } chr_t;

  dup_tx_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .dupINIT  (dupINIT),
    .txLOAD   (txLOAD),
    .txDAT    (txDAT),
    .txSOM    (txSOM),
    .txEOM    (txEOM),
    .txABRT   (txABRT),
    .txEN     (txEN),
    .txTICK   (txTICK),
    .txDATA   (txDATA),
    .txDONE   (txDONE),
    .txACT    (txACT),
    .dupTXCRC (dupTXCRC)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic chr_t mk(bit s, bit e, bit a, bit [7:0] d);
    chr_t c;
    c.som = s; c.eom = e; c.abrt = a; c.dat = d;
    return c;
  endfunction

  function automatic bit [15:0] crc_bit(bit [15:0] c, bit b);
    bit fb;
    fb = c[0] ^ b;
    return (c >> 1) ^ (fb ? 16'hA001 : 16'h0000);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input chr_t c);
    txDAT = c.dat; txSOM = c.som; txEOM = c.eom; txABRT = c.abrt;
    txLOAD = 1'b1;
    cyc();
    txLOAD = 1'b0;
  endtask

  task automatic tick(output bit ln, output bit ac, output bit cb);
    txTICK = 1'b1;
    cyc();
    txTICK = 1'b0;
    ln = txDATA; ac = txACT; cb = dupTXCRC;
    cyc();
    cyc();
  endtask

  // Feeds characters whenever txDONE shows the holding register empty and
  // checks line/activity against the expected serial image of the message.
  task automatic run_stream(input string nm, input chr_t cq[$], input bit pre,
                            output bit cap[$], output bit capc[$]);
    bit eb[$];
    bit ln, ac, cb, e;
    int fi, nt;
    cap.delete(); capc.delete();
    foreach (cq[k]) begin
      if (cq[k].abrt) begin
        repeat (8) eb.push_back(1'b1);
        m_crc = 16'h0000;
      end else if (cq[k].eom) begin
        for (int b = 0; b < 16; b++) eb.push_back(m_crc[b]);
        m_crc = 16'h0000;
      end else begin
        if (cq[k].som) m_crc = 16'h0000;
        for (int b = 0; b < 8; b++) begin
          eb.push_back(cq[k].dat[b]);
          if (!cq[k].som) m_crc = crc_bit(m_crc, cq[k].dat[b]);
        end
      end
    end
    nt = eb.size() + 4;
    fi = pre ? 1 : 0;
    for (int t = 0; t < nt; t++) begin
      if (fi < cq.size() && txDONE) begin
        load(cq[fi]);
        fi++;
      end
      tick(ln, ac, cb);
      cap.push_back(ln);
      capc.push_back(cb);
      e = (t >= 1 && t <= eb.size()) ? eb[t-1] : 1'b1;
      n_tot++;
      if (ln !== e) $display("FAIL %s line t=%0d got %b want %b", nm, t, ln, e);
      else n_pass++;
      e = (t < eb.size());
      n_tot++;
      if (ac !== e) $display("FAIL %s txACT t=%0d got %b want %b", nm, t, ac, e);
      else n_pass++;
    end
    n_tot++;
    if (fi !== cq.size()) $display("FAIL %s fed got %0d want %0d", nm, fi, cq.size());
    else n_pass++;
    n_tot++;
    if (dupTXCRC !== m_crc[0])
      $display("FAIL %s final crc0 got %b want %b", nm, dupTXCRC, m_crc[0]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0; txEN = 1'b0;
    repeat (3) cyc();
    n_tot++; if (txDATA !== 1'b1) $display("FAIL rst txDATA got %b want 1", txDATA); else n_pass++;
    n_tot++; if (txDONE !== 1'b0) $display("FAIL rst txDONE got %b want 0", txDONE); else n_pass++;
    n_tot++; if (txACT !== 1'b0) $display("FAIL rst txACT got %b want 0", txACT); else n_pass++;
    n_tot++; if (dupTXCRC !== 1'b0) $display("FAIL rst crc0 got %b want 0", dupTXCRC); else n_pass++;
    rst = 1'b1;
    cyc(); cyc();
    n_tot++; if (txDONE !== 1'b0) $display("FAIL rst done_noen got %b want 0", txDONE); else n_pass++;
    txEN = 1'b1;
    cyc(); cyc();
    n_tot++; if (txDONE !== 1'b1) $display("FAIL rst done_en got %b want 1", txDONE); else n_pass++;
  endtask

  task automatic test_single();
    chr_t cq[$];
    bit cap[$], capc[$];
    bit [7:0] got;
    bit [15:0] c;
    cq.push_back(mk(0, 0, 0, 8'h96));
    run_stream("single", cq, 1'b0, cap, capc);
    for (int i = 0; i < 8; i++) got[i] = cap[1+i];
    n_tot++; if (got !== 8'h96) $display("FAIL single bits got %h want 96", got); else n_pass++;
    c = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      c = crc_bit(c, got[i]);
      n_tot++;
      if (capc[1+i] !== c[0]) $display("FAIL single crc0 bit%0d got %b want %b", i, capc[1+i], c[0]);
      else n_pass++;
    end
  endtask

  task automatic test_known_crc();
    chr_t cq[$];
    bit cap[$], capc[$];
    bit [15:0] got;
    cq.push_back(mk(1, 0, 0, 8'h96));
    for (int d = 0; d < 9; d++) cq.push_back(mk(0, 0, 0, 8'(8'h31 + d)));
    cq.push_back(mk(0, 1, 0, 8'hFF));
    run_stream("known", cq, 1'b0, cap, capc);
    for (int i = 0; i < 16; i++) got[i] = cap[81+i];
    n_tot++; if (got !== 16'hBB3D) $display("FAIL known crc got %h want bb3d", got); else n_pass++;
  endtask

  task automatic test_abort();
    chr_t cq[$];
    bit cap[$], capc[$];
    cq.push_back(mk(0, 0, 0, 8'h55));
    cq.push_back(mk(0, 0, 1, 8'h00));
    run_stream("abort", cq, 1'b0, cap, capc);
    n_tot++; if (txDONE !== 1'b1) $display("FAIL abort txDONE got %b want 1", txDONE); else n_pass++;
  endtask

  task automatic test_underrun();
    chr_t cq[$];
    bit cap[$], capc[$];
    cq.push_back(mk(0, 0, 0, 8'($urandom_range(0, 255))));
    run_stream("underrun_a", cq, 1'b0, cap, capc);
    repeat (5) cyc();
    cq.delete();
    cq.push_back(mk(0, 0, 0, 8'($urandom_range(0, 255))));
    run_stream("underrun_b", cq, 1'b0, cap, capc);
  endtask

  task automatic test_random_msgs();
    chr_t cq[$];
    bit cap[$], capc[$];
    for (int r = 0; r < 4; r++) begin
      cq.delete();
      for (int m = 0; m < 3; m++) begin
        cq.push_back(mk(1, 0, 0, 8'($urandom_range(0, 255))));
        repeat ($urandom_range(1, 4)) cq.push_back(mk(0, 0, 0, 8'($urandom_range(0, 255))));
        cq.push_back(mk(0, 1, 0, 8'($urandom_range(0, 255))));
      end
      if (r == 3) cq.push_back(mk(0, 0, 1, 8'h00));
      run_stream($sformatf("rand%0d", r), cq, 1'b0, cap, capc);
    end
  endtask

  task automatic test_en_drop();
    chr_t ca, cb_q[$];
    bit cap[$], capc[$];
    bit ln, ac, cb;
    bit [7:0] got;
    ca = mk(0, 0, 0, 8'($urandom_range(0, 255)));
    cb_q.push_back(mk(0, 0, 0, 8'($urandom_range(0, 255))));
    load(ca);
    for (int t = 0; t < 10; t++) begin
      if (t == 4) begin
        txEN = 1'b0;
        load(cb_q[0]);
      end
      tick(ln, ac, cb);
      if (t >= 1 && t <= 8) got[t-1] = ln;
      if (t == 8) begin
        n_tot++; if (ac !== 1'b0) $display("FAIL endrop txACT got %b want 0", ac); else n_pass++;
      end
      if (t == 9) begin
        n_tot++; if (ln !== 1'b1) $display("FAIL endrop idle line got %b want 1", ln); else n_pass++;
      end
    end
    n_tot++; if (got !== ca.dat) $display("FAIL endrop byte got %h want %h", got, ca.dat); else n_pass++;
    n_tot++; if (txDONE !== 1'b0) $display("FAIL endrop txDONE got %b want 0", txDONE); else n_pass++;
    for (int b = 0; b < 8; b++) m_crc = crc_bit(m_crc, ca.dat[b]);
    txEN = 1'b1;
    cyc(); cyc();
    run_stream("en_resume", cb_q, 1'b1, cap, capc);
  endtask

  task automatic test_init();
    chr_t cq[$];
    bit cap[$], capc[$];
    bit ln, ac, cb, bad;
    int fi;
    cq.push_back(mk(1, 0, 0, 8'h7E));
    cq.push_back(mk(0, 0, 0, 8'hA5));
    cq.push_back(mk(0, 1, 0, 8'h00));
    fi = 0;
    for (int t = 0; t < 22; t++) begin
      if (fi < 3 && txDONE) begin
        load(cq[fi]);
        fi++;
      end
      tick(ln, ac, cb);
    end
    n_tot++; if (txACT !== 1'b1) $display("FAIL init pre txACT got %b want 1", txACT); else n_pass++;
    dupINIT = 1'b1; txLOAD = 1'b1; txDAT = 8'h11; txSOM = 1'b0; txEOM = 1'b0; txABRT = 1'b0;
    cyc();
    dupINIT = 1'b0; txLOAD = 1'b0;
    n_tot++; if (txACT !== 1'b0) $display("FAIL init txACT got %b want 0", txACT); else n_pass++;
    n_tot++; if (txDATA !== 1'b1) $display("FAIL init txDATA got %b want 1", txDATA); else n_pass++;
    n_tot++; if (dupTXCRC !== 1'b0) $display("FAIL init crc0 got %b want 0", dupTXCRC); else n_pass++;
    n_tot++; if (txDONE !== 1'b0) $display("FAIL init txDONE got %b want 0", txDONE); else n_pass++;
    cyc(); cyc();
    n_tot++; if (txDONE !== 1'b1) $display("FAIL init hold_empty got %b want 1", txDONE); else n_pass++;
    bad = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick(ln, ac, cb);
      if (ln !== 1'b1 || ac !== 1'b0) bad = 1'b1;
    end
    n_tot++; if (bad !== 1'b0) $display("FAIL init idle_after got %b want 0", bad); else n_pass++;
    m_crc = 16'h0000;
    cq.delete();
    cq.push_back(mk(0, 0, 0, 8'($urandom_range(0, 255))));
    run_stream("init_restart", cq, 1'b0, cap, capc);
  endtask

  initial begin
    test_reset();
    test_single();
    test_known_crc();
    test_abort();
    test_underrun();
    test_random_msgs();
    test_en_drop();
    test_init();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
